// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/LSU memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request, response and memory-side signals of the arbiter, grouped for binding.
interface mem_arbiter_if #(
  parameter int DW    = 32,
  parameter int MASKW = DW / 8
);

  // Handshake: a requester raises req with its payload and holds them all stable
  // until gnt is seen in the same cycle; gnt is combinational and means accepted.
  // rvalid follows exactly one cycle after gnt and is never back-pressured.
  logic             if_req_i;
  logic [DW-1:0]    if_addr_i;
  logic             if_gnt_o;
  logic             if_rvalid_o;
  logic [DW-1:0]    if_rdata_o;

  logic             ls_req_i;
  logic             ls_we_i;
  logic [DW-1:0]    ls_addr_i;
  logic [DW-1:0]    ls_wdata_i;
  logic [MASKW-1:0] ls_mask_i;
  logic             ls_gnt_o;
  logic             ls_rvalid_o;
  logic [DW-1:0]    ls_rdata_o;

  logic             stall_if_o;
  logic             stall_ls_o;

  logic             mem_req_o;
  logic             mem_we_o;
  logic [DW-1:0]    mem_addr_o;
  logic [DW-1:0]    mem_wdata_o;
  logic [MASKW-1:0] mem_mask_o;
  logic [DW-1:0]    mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_mask_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output stall_if_o, stall_ls_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_mask_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_mask_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  stall_if_o, stall_ls_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_mask_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating counter of consecutive LSU-over-fetch wins; sat forces fetch through.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              inc,
  input  logic                              clr,
  output logic                              sat,
  output logic [$clog2(STARVE_MAX+1)-1:0]   cnt
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  assign sat = (cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: LSU priority with a fetch starvation guard,
// zero-latency grant and one-cycle response routing by registered owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DW         = 32,
  parameter int MASKW      = DW / 8,
  parameter int STARVE_MAX = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  mem_arbiter_if.slave                     bus,
  output owner_e                           dbg_owner,
  output logic [$clog2(STARVE_MAX+1)-1:0]  dbg_starve_cnt
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  owner_e          owner_q;
  logic            sat;
  logic            if_win;
  logic            ls_win;
  logic            if_gnt;
  logic            ls_gnt;
  logic [CW-1:0]   starve_cnt;

  // Fetch wins alone, or against the LSU once it has been passed over STARVE_MAX times.
  assign if_win = bus.if_req_i & (~bus.ls_req_i | sat);
  assign ls_win = bus.ls_req_i & ~if_win;
  assign if_gnt = if_win & ~rst_i;
  assign ls_gnt = ls_win & ~rst_i;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (bus.if_req_i & ls_gnt),
    .clr   (if_gnt | ~bus.if_req_i),
    .sat   (sat),
    .cnt   (starve_cnt)
  );

  assign bus.if_gnt_o   = if_gnt;
  assign bus.ls_gnt_o   = ls_gnt;
  assign bus.stall_if_o = bus.if_req_i & ~if_gnt & ~rst_i;
  assign bus.stall_ls_o = bus.ls_req_i & ~ls_gnt & ~rst_i;

  always_comb begin
    bus.mem_req_o   = if_gnt | ls_gnt;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = {DW{1'b0}};
    bus.mem_wdata_o = {DW{1'b0}};
    bus.mem_mask_o  = {MASKW{1'b0}};
    if (ls_gnt) begin
      bus.mem_we_o    = bus.ls_we_i;
      bus.mem_addr_o  = bus.ls_addr_i;
      bus.mem_wdata_o = bus.ls_wdata_i;
      bus.mem_mask_o  = bus.ls_mask_i;
    end else if (if_gnt) begin
      bus.mem_addr_o  = bus.if_addr_i;
    end
  end

  // Owner of the access whose data returns this cycle; reset drops any in-flight response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
    end else if (if_gnt) begin
      owner_q <= OWN_IF;
    end else if (ls_gnt) begin
      owner_q <= OWN_LS;
    end else begin
      owner_q <= OWN_NONE;
    end
  end

  assign bus.if_rvalid_o = (owner_q == OWN_IF);
  assign bus.ls_rvalid_o = (owner_q == OWN_LS);
  assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : {DW{1'b0}};
  assign bus.ls_rdata_o  = bus.ls_rvalid_o ? bus.mem_rdata_i : {DW{1'b0}};

  assign dbg_owner      = owner_q;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven on the falling edge, outputs sampled 1 later.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DW         = 32;
  localparam int MASKW      = 4;
  localparam int STARVE_MAX = 3;
  localparam int CW         = $clog2(STARVE_MAX + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  owner_e        dbg_owner;
  logic [CW-1:0] dbg_starve_cnt;
  int            errors = 0;
  int            checks = 0;

  mem_arbiter_if #(.DW(DW), .MASKW(MASKW)) bus ();

  mem_arbiter #(
    .DW         (DW),
    .MASKW      (MASKW),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .bus            (bus.slave),
    .dbg_owner      (dbg_owner),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // driver tasks
  task automatic drive_idle();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.ls_req_i   = 1'b0;
    bus.ls_we_i    = 1'b0;
    bus.ls_addr_i  = '0;
    bus.ls_wdata_i = '0;
    bus.ls_mask_i  = '0;
  endtask

  task automatic drive_fetch(input logic [DW-1:0] a);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = a;
  endtask

  task automatic drive_ls(input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d,
                          input logic [MASKW-1:0] m);
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = we;
    bus.ls_addr_i  = a;
    bus.ls_wdata_i = d;
    bus.ls_mask_i  = m;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive_fetch(32'h4);
    drive_ls(1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF);
    bus.mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i); #1;
    checks++; if (bus.if_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_if_gnt: got %b exp 0", bus.if_gnt_o); end
    checks++; if (bus.ls_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_ls_gnt: got %b exp 0", bus.ls_gnt_o); end
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b exp 0", bus.mem_req_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b exp 0", bus.mem_we_o); end
    checks++; if (bus.stall_if_o !== 1'b0) begin errors++; $display("FAIL rst_stall_if: got %b exp 0", bus.stall_if_o); end
    checks++; if (bus.stall_ls_o !== 1'b0) begin errors++; $display("FAIL rst_stall_ls: got %b exp 0", bus.stall_ls_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    drive_idle();
    bus.mem_rdata_i = 32'hCAFE_F00D;
    #1;
    checks++; if (dbg_owner !== OWN_NONE) begin errors++; $display("FAIL rst_owner: got %0d exp 0", dbg_owner); end
    checks++; if (dbg_starve_cnt !== '0) begin errors++; $display("FAIL rst_starve: got %0d exp 0", dbg_starve_cnt); end
    checks++; if (bus.if_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_if_rvalid: got %b exp 0", bus.if_rvalid_o); end
    checks++; if (bus.ls_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_ls_rvalid: got %b exp 0", bus.ls_rvalid_o); end
    checks++; if (bus.if_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_if_rdata: got %h exp 0", bus.if_rdata_o); end
    checks++; if (bus.ls_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_ls_rdata: got %h exp 0", bus.ls_rdata_o); end
  endtask

  task automatic test_idle();
    @(negedge clk_i);
    drive_idle();
    bus.mem_rdata_i = 32'h1234_5678;
    #1;
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL idle_mem_req: got %b exp 0", bus.mem_req_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL idle_mem_we: got %b exp 0", bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL idle_mem_addr: got %h exp 0", bus.mem_addr_o); end
    checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL idle_mem_wdata: got %h exp 0", bus.mem_wdata_o); end
    checks++; if (bus.mem_mask_o !== 4'h0) begin errors++; $display("FAIL idle_mem_mask: got %h exp 0", bus.mem_mask_o); end
    checks++; if ({bus.stall_if_o, bus.stall_ls_o} !== 2'b00) begin errors++; $display("FAIL idle_stalls: got %b exp 00", {bus.stall_if_o, bus.stall_ls_o}); end
    @(negedge clk_i); #1;
    checks++; if ({bus.if_rvalid_o, bus.ls_rvalid_o} !== 2'b00) begin errors++; $display("FAIL idle_rvalids: got %b exp 00", {bus.if_rvalid_o, bus.ls_rvalid_o}); end
  endtask

  task automatic test_fetch_only();
    @(negedge clk_i);
    drive_idle();
    drive_fetch(32'h10);
    #1;
    checks++; if (bus.if_gnt_o !== 1'b1) begin errors++; $display("FAIL fetch_gnt: got %b exp 1", bus.if_gnt_o); end
    checks++; if (bus.ls_gnt_o !== 1'b0) begin errors++; $display("FAIL fetch_ls_gnt: got %b exp 0", bus.ls_gnt_o); end
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL fetch_mem_req: got %b exp 1", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== 32'h10) begin errors++; $display("FAIL fetch_mem_addr: got %h exp 10", bus.mem_addr_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL fetch_mem_we: got %b exp 0", bus.mem_we_o); end
    checks++; if (bus.stall_if_o !== 1'b0) begin errors++; $display("FAIL fetch_stall_if: got %b exp 0", bus.stall_if_o); end
    @(negedge clk_i);
    drive_idle();
    bus.mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.if_rvalid_o !== 1'b1) begin errors++; $display("FAIL fetch_rvalid: got %b exp 1", bus.if_rvalid_o); end
    checks++; if (bus.if_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_rdata: got %h exp deadbeef", bus.if_rdata_o); end
    checks++; if (bus.ls_rvalid_o !== 1'b0) begin errors++; $display("FAIL fetch_ls_rvalid: got %b exp 0", bus.ls_rvalid_o); end
    checks++; if (bus.ls_rdata_o !== 32'h0) begin errors++; $display("FAIL fetch_ls_rdata: got %h exp 0", bus.ls_rdata_o); end
  endtask

  task automatic test_store();
    @(negedge clk_i);
    drive_idle();
    drive_ls(1'b1, 32'h200, 32'h1234_5678, 4'b0011);
    #1;
    checks++; if (bus.ls_gnt_o !== 1'b1) begin errors++; $display("FAIL store_gnt: got %b exp 1", bus.ls_gnt_o); end
    checks++; if (bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL store_mem_we: got %b exp 1", bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== 32'h200) begin errors++; $display("FAIL store_mem_addr: got %h exp 200", bus.mem_addr_o); end
    checks++; if (bus.mem_wdata_o !== 32'h1234_5678) begin errors++; $display("FAIL store_mem_wdata: got %h exp 12345678", bus.mem_wdata_o); end
    checks++; if (bus.mem_mask_o !== 4'b0011) begin errors++; $display("FAIL store_mem_mask: got %b exp 0011", bus.mem_mask_o); end
    @(negedge clk_i);
    drive_idle();
    bus.mem_rdata_i = 32'h5555_AAAA;
    #1;
    checks++; if (bus.ls_rvalid_o !== 1'b1) begin errors++; $display("FAIL store_rvalid: got %b exp 1", bus.ls_rvalid_o); end
    checks++; if (bus.ls_rdata_o !== 32'h5555_AAAA) begin errors++; $display("FAIL store_rdata: got %h exp 5555aaaa", bus.ls_rdata_o); end
    checks++; if (bus.if_rvalid_o !== 1'b0) begin errors++; $display("FAIL store_if_rvalid: got %b exp 0", bus.if_rvalid_o); end
  endtask

  task automatic test_contention();
    logic [4:0] exp_if_w;
    int         exp_cnt[5];
    exp_if_w = 5'b01000;
    exp_cnt  = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      drive_fetch(32'h40);
      drive_ls(1'b0, 32'h400, 32'h0, 4'h0);
      #1;
      checks++; if (bus.if_gnt_o !== exp_if_w[i]) begin errors++; $display("FAIL cont_if_gnt[%0d]: got %b exp %b", i, bus.if_gnt_o, exp_if_w[i]); end
      checks++; if (bus.ls_gnt_o !== ~exp_if_w[i]) begin errors++; $display("FAIL cont_ls_gnt[%0d]: got %b exp %b", i, bus.ls_gnt_o, ~exp_if_w[i]); end
      checks++; if (bus.stall_if_o !== ~exp_if_w[i]) begin errors++; $display("FAIL cont_stall_if[%0d]: got %b exp %b", i, bus.stall_if_o, ~exp_if_w[i]); end
      checks++; if (bus.stall_ls_o !== exp_if_w[i]) begin errors++; $display("FAIL cont_stall_ls[%0d]: got %b exp %b", i, bus.stall_ls_o, exp_if_w[i]); end
      checks++; if (dbg_starve_cnt !== CW'(exp_cnt[i])) begin errors++; $display("FAIL cont_starve[%0d]: got %0d exp %0d", i, dbg_starve_cnt, exp_cnt[i]); end
      checks++; if (bus.mem_addr_o !== (exp_if_w[i] ? 32'h40 : 32'h400)) begin errors++; $display("FAIL cont_mem_addr[%0d]: got %h", i, bus.mem_addr_o); end
    end
    @(negedge clk_i);
    drive_idle();
    bus.mem_rdata_i = 32'h1111_2222;
    #1;
    checks++; if (bus.ls_rvalid_o !== 1'b1) begin errors++; $display("FAIL cont_last_rvalid: got %b exp 1", bus.ls_rvalid_o); end
    checks++; if (bus.ls_rdata_o !== 32'h1111_2222) begin errors++; $display("FAIL cont_last_rdata: got %h exp 11112222", bus.ls_rdata_o); end
  endtask

  task automatic test_starve_clear();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      drive_fetch(32'h44);
      drive_ls(1'b0, 32'h404, 32'h0, 4'h0);
      #1;
      checks++; if (dbg_starve_cnt !== CW'(i)) begin errors++; $display("FAIL clr_starve_pre[%0d]: got %0d exp %0d", i, dbg_starve_cnt, i); end
    end
    @(negedge clk_i);
    bus.if_req_i = 1'b0;
    #1;
    checks++; if (dbg_starve_cnt !== CW'(2)) begin errors++; $display("FAIL clr_starve_hold: got %0d exp 2", dbg_starve_cnt); end
    checks++; if (bus.stall_if_o !== 1'b0) begin errors++; $display("FAIL clr_stall_if: got %b exp 0", bus.stall_if_o); end
    @(negedge clk_i);
    drive_fetch(32'h44);
    #1;
    checks++; if (dbg_starve_cnt !== CW'(0)) begin errors++; $display("FAIL clr_starve_after: got %0d exp 0", dbg_starve_cnt); end
    checks++; if (bus.ls_gnt_o !== 1'b1) begin errors++; $display("FAIL clr_ls_gnt: got %b exp 1", bus.ls_gnt_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    drive_idle();
    drive_ls(1'b0, 32'h300, 32'h0, 4'h0);
    #1;
    checks++; if (bus.ls_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_ls_gnt: got %b exp 1", bus.ls_gnt_o); end
    checks++; if (bus.mem_addr_o !== 32'h300) begin errors++; $display("FAIL b2b_ls_addr: got %h exp 300", bus.mem_addr_o); end
    @(negedge clk_i);
    drive_idle();
    drive_fetch(32'h20);
    bus.mem_rdata_i = 32'hAAAA_0001;
    #1;
    checks++; if (dbg_owner !== OWN_LS) begin errors++; $display("FAIL b2b_owner_ls: got %0d exp 2", dbg_owner); end
    checks++; if (bus.ls_rdata_o !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_ls_rdata: got %h exp aaaa0001", bus.ls_rdata_o); end
    checks++; if (bus.if_rdata_o !== 32'h0) begin errors++; $display("FAIL b2b_if_rdata_0: got %h exp 0", bus.if_rdata_o); end
    checks++; if (bus.if_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_if_gnt: got %b exp 1", bus.if_gnt_o); end
    checks++; if (bus.mem_addr_o !== 32'h20) begin errors++; $display("FAIL b2b_if_addr: got %h exp 20", bus.mem_addr_o); end
    @(negedge clk_i);
    drive_idle();
    bus.mem_rdata_i = 32'hBBBB_0002;
    #1;
    checks++; if (dbg_owner !== OWN_IF) begin errors++; $display("FAIL b2b_owner_if: got %0d exp 1", dbg_owner); end
    checks++; if (bus.if_rdata_o !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_if_rdata: got %h exp bbbb0002", bus.if_rdata_o); end
    checks++; if (bus.ls_rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_ls_rvalid: got %b exp 0", bus.ls_rvalid_o); end
  endtask

  task automatic test_reset_counter();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      drive_fetch(32'h48);
      drive_ls(1'b0, 32'h408, 32'h0, 4'h0);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++; if (dbg_starve_cnt !== CW'(2)) begin errors++; $display("FAIL rcnt_before: got %0d exp 2", dbg_starve_cnt); end
    checks++; if ({bus.if_gnt_o, bus.ls_gnt_o, bus.mem_req_o} !== 3'b000) begin errors++; $display("FAIL rcnt_gnts: got %b exp 000", {bus.if_gnt_o, bus.ls_gnt_o, bus.mem_req_o}); end
    @(negedge clk_i);
    rst_i = 1'b0;
    drive_idle();
    #1;
    checks++; if (dbg_starve_cnt !== CW'(0)) begin errors++; $display("FAIL rcnt_after: got %0d exp 0", dbg_starve_cnt); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk_i);
    drive_idle();
    drive_fetch(32'h80);
    #1;
    checks++; if (bus.if_gnt_o !== 1'b1) begin errors++; $display("FAIL mid_if_gnt: got %b exp 1", bus.if_gnt_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++; if (bus.if_gnt_o !== 1'b0) begin errors++; $display("FAIL mid_rst_gnt: got %b exp 0", bus.if_gnt_o); end
    checks++; if (bus.stall_if_o !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %b exp 0", bus.stall_if_o); end
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL mid_rst_mem_req: got %b exp 0", bus.mem_req_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    drive_idle();
    bus.mem_rdata_i = 32'h0000_0077;
    #1;
    checks++; if (bus.if_rvalid_o !== 1'b0) begin errors++; $display("FAIL mid_if_rvalid: got %b exp 0", bus.if_rvalid_o); end
    checks++; if (bus.if_rdata_o !== 32'h0) begin errors++; $display("FAIL mid_if_rdata: got %h exp 0", bus.if_rdata_o); end
    checks++; if (dbg_owner !== OWN_NONE) begin errors++; $display("FAIL mid_owner: got %0d exp 0", dbg_owner); end
    checks++; if (dbg_starve_cnt !== CW'(0)) begin errors++; $display("FAIL mid_starve: got %0d exp 0", dbg_starve_cnt); end
  endtask

  initial begin
    rst_i = 1'b1;
    drive_idle();
    bus.mem_rdata_i = '0;
    test_reset();
    test_idle();
    test_fetch_only();
    test_store();
    test_contention();
    test_starve_clear();
    test_back_to_back();
    test_reset_counter();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
